// File: rtl/pet_video_timing_pkg.sv
// pet_video_timing_pkg: slot phase map, CRTC register widths and shared compare helpers.
package pet_video_timing_pkg;
   localparam int PHASE_W = 4;
   localparam int ADDR_W  = 12;
   localparam int HW = 8, HSW = 4, VHW = 5, VW = 7, VSW = 4, VAW = 5;
   localparam logic [PHASE_W-1:0] PI_START         = 4'd0;
   localparam logic [PHASE_W-1:0] PI_END           = 4'd3;
   localparam logic [PHASE_W-1:0] PI_STROBE_START  = 4'd1;
   localparam logic [PHASE_W-1:0] PI_STROBE_END    = 4'd2;
   localparam logic [PHASE_W-1:0] VIDEO_START      = 4'd4;
   localparam logic [PHASE_W-1:0] VIDEO_END        = 4'd9;
   localparam logic [PHASE_W-1:0] VIDEO_RAM_PHASE  = 4'd5;
   localparam logic [PHASE_W-1:0] VIDEO_ROM_PHASE  = 4'd8;
   localparam logic [PHASE_W-1:0] IO_START         = 4'd9;
   localparam logic [PHASE_W-1:0] CPU_START        = 4'd10;
   localparam logic [PHASE_W-1:0] CPU_STROBE_START = 4'd11;
   localparam logic [PHASE_W-1:0] CPU_STROBE_END   = 4'd14;
   localparam logic [PHASE_W-1:0] LOAD_PHASE       = 4'd15;

   typedef struct packed {
      logic [HW-1:0]  h_total;
      logic [HW-1:0]  h_disp;
      logic [HW-1:0]  h_sync_pos;
      logic [HSW-1:0] h_sync_width;
      logic [VHW-1:0] v_height;
      logic [VW-1:0]  v_total;
      logic [VW-1:0]  v_disp;
      logic [VW-1:0]  v_sync_pos;
      logic [VSW-1:0] v_sync_width;
      logic [VAW-1:0] v_adjust;
   } crtc_regs_t;

   function automatic logic in_phase(input logic [PHASE_W-1:0] p, input logic [PHASE_W-1:0] lo,
                                     input logic [PHASE_W-1:0] hi);
      return p >= lo && p <= hi;
   endfunction

   // Widened sum so a sync window near the top of the range cannot wrap; zero width is empty.
   function automatic logic in_window(input logic [7:0] val, input logic [7:0] pos, input logic [3:0] width);
      return val >= pos && {1'b0, val} < {1'b0, pos} + {5'd0, width};
   endfunction
endpackage

// File: rtl/pet_video_timing_crtc_timing.sv
// pet_video_timing_crtc_timing: character/scanline/row counters with sync and active compares.
// Counters advance once per character; timing outputs are registered one character late.
module pet_video_timing_crtc_timing
   import pet_video_timing_pkg::*;
(
   input  logic              clk16,
   input  logic              reset_n,
   input  logic              i_adv,
   input  crtc_regs_t        i_regs,
   output logic [ADDR_W-1:0] o_ma,
   output logic [3:0]        o_ra,
   output logic              o_active,
   output logic              o_h_sync,
   output logic              o_h_active,
   output logic              o_v_sync,
   output logic              o_v_active
);
   logic [HW-1:0]     r_h, w_h_n;
   logic [VW-1:0]     r_v, w_v_n;
   logic [VHW-1:0]    r_ra, w_ra_n;
   logic [ADDR_W-1:0] r_row, w_row_n;
   logic              r_adj, w_adj_n;
   logic              w_h_wrap, w_ra_wrap, w_adj_end, w_h_act;
   logic              r_h_sync, r_h_active, r_v_sync, r_v_active;

   assign w_h_act    = r_h < i_regs.h_disp;
   assign o_active   = w_h_act && !r_adj && r_v < i_regs.v_disp;
   assign o_ma       = r_row + {4'd0, r_h};
   assign o_ra       = r_ra[3:0];
   assign o_h_sync   = r_h_sync;
   assign o_h_active = r_h_active;
   assign o_v_sync   = r_v_sync;
   assign o_v_active = r_v_active;

   // ">=" rather than "==" so a counter stranded above a shrunken total still wraps.
   always_comb begin
      w_h_wrap  = r_h >= i_regs.h_total;
      w_ra_wrap = r_ra >= i_regs.v_height;
      w_adj_end = {1'b0, r_ra} + 6'd1 >= {1'b0, i_regs.v_adjust};
      w_h_n     = w_h_wrap ? '0 : r_h + 8'd1;
      w_v_n     = r_v;
      w_ra_n    = r_ra;
      w_row_n   = r_row;
      w_adj_n   = r_adj;
      if (w_h_wrap) begin
         if (r_adj ? w_adj_end : (w_ra_wrap && r_v >= i_regs.v_total && i_regs.v_adjust == '0)) begin
            w_v_n   = '0;
            w_ra_n  = '0;
            w_row_n = '0;
            w_adj_n = 1'b0;
         end else if (r_adj || !w_ra_wrap) begin
            w_ra_n = r_ra + 5'd1;
         end else if (r_v < i_regs.v_total) begin
            w_v_n   = r_v + 7'd1;
            w_ra_n  = '0;
            w_row_n = r_row + {4'd0, i_regs.h_disp};
         end else begin
            w_adj_n = 1'b1;
            w_ra_n  = '0;
         end
      end
   end

   always_ff @(posedge clk16 or negedge reset_n) begin
      if (!reset_n) begin
         r_h        <= '0;
         r_v        <= '0;
         r_ra       <= '0;
         r_row      <= '0;
         r_adj      <= 1'b0;
         r_h_sync   <= 1'b0;
         r_h_active <= 1'b0;
         r_v_sync   <= 1'b0;
         r_v_active <= 1'b0;
      end else if (i_adv) begin
         r_h        <= w_h_n;
         r_v        <= w_v_n;
         r_ra       <= w_ra_n;
         r_row      <= w_row_n;
         r_adj      <= w_adj_n;
         r_h_active <= w_h_act;
         r_h_sync   <= in_window(r_h, i_regs.h_sync_pos, i_regs.h_sync_width);
         r_v_active <= !w_adj_n && w_v_n < i_regs.v_disp;
         r_v_sync   <= !w_adj_n && in_window({1'b0, w_v_n}, {1'b0, i_regs.v_sync_pos}, i_regs.v_sync_width);
      end
   end
endmodule

// File: rtl/pet_video_timing.sv
// pet_video_timing: PET bus-slot sequencer and character video generator.
// Phase decode, fetch address mux and pixel shifter around the CRTC counters.
module pet_video_timing
   import pet_video_timing_pkg::*;
(
   input  logic              clk16,
   input  logic              reset_n,
   output logic              pi_select,
   output logic              pi_strobe,
   output logic              video_select,
   output logic              video_ram_strobe,
   output logic              video_rom_strobe,
   output logic              cpu_select,
   output logic              io_select,
   output logic              cpu_strobe,
   output logic [ADDR_W-1:0] addr_out,
   input  logic [7:0]        data_in,
   input  logic [7:0]        h_char_total,
   input  logic [7:0]        h_char_displayed,
   input  logic [7:0]        h_sync_pos,
   input  logic [3:0]        h_sync_width,
   input  logic [4:0]        v_char_height,
   input  logic [6:0]        v_char_total,
   input  logic [6:0]        v_char_displayed,
   input  logic [6:0]        v_sync_pos,
   input  logic [3:0]        v_sync_width,
   input  logic [4:0]        v_adjust,
   output logic              video,
   output logic              h_sync,
   output logic              h_active,
   output logic              v_sync,
   output logic              v_active
);
   logic [PHASE_W-1:0] r_phase, w_phase_n;
   logic [7:0]         r_slots, w_slots;
   logic [ADDR_W-1:0]  r_addr, w_ma;
   logic [7:0]         r_char, r_rom, r_shift;
   logic [3:0]         w_ra;
   logic               w_active, w_load;
   crtc_regs_t         w_regs;

   assign w_phase_n = r_phase + 4'd1;
   assign w_load    = r_phase == LOAD_PHASE;
   assign addr_out  = r_addr;
   assign video     = r_shift[7];
   assign w_regs    = '{h_total: h_char_total, h_disp: h_char_displayed, h_sync_pos: h_sync_pos,
                        h_sync_width: h_sync_width, v_height: v_char_height, v_total: v_char_total,
                        v_disp: v_char_displayed, v_sync_pos: v_sync_pos, v_sync_width: v_sync_width,
                        v_adjust: v_adjust};
   // Decoded from the next phase so each registered slot lines up with the phase it names.
   assign w_slots   = {in_phase(w_phase_n, PI_START, PI_END),
                       in_phase(w_phase_n, PI_STROBE_START, PI_STROBE_END),
                       in_phase(w_phase_n, VIDEO_START, VIDEO_END),
                       in_phase(w_phase_n, VIDEO_RAM_PHASE, VIDEO_RAM_PHASE),
                       in_phase(w_phase_n, VIDEO_ROM_PHASE, VIDEO_ROM_PHASE),
                       in_phase(w_phase_n, CPU_START, LOAD_PHASE),
                       in_phase(w_phase_n, IO_START, LOAD_PHASE),
                       in_phase(w_phase_n, CPU_STROBE_START, CPU_STROBE_END)};
   assign {pi_select, pi_strobe, video_select, video_ram_strobe, video_rom_strobe,
           cpu_select, io_select, cpu_strobe} = r_slots;

   pet_video_timing_crtc_timing u_crtc (
      .clk16      (clk16),
      .reset_n    (reset_n),
      .i_adv      (w_load),
      .i_regs     (w_regs),
      .o_ma       (w_ma),
      .o_ra       (w_ra),
      .o_active   (w_active),
      .o_h_sync   (h_sync),
      .o_h_active (h_active),
      .o_v_sync   (v_sync),
      .o_v_active (v_active)
   );

   // Address is held one phase either side of each strobe; new pixels start on even phases.
   always_ff @(posedge clk16 or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= '0;
         r_slots <= '0;
         r_addr  <= '0;
         r_char  <= '0;
         r_rom   <= '0;
         r_shift <= '0;
      end else begin
         r_phase <= w_phase_n;
         r_slots <= w_slots;
         if (in_phase(w_phase_n, VIDEO_RAM_PHASE - 4'd1, VIDEO_RAM_PHASE + 4'd1))
            r_addr <= w_ma;
         else if (in_phase(w_phase_n, VIDEO_ROM_PHASE - 4'd1, VIDEO_ROM_PHASE + 4'd1))
            r_addr <= {r_char, w_ra};
         if (r_phase == VIDEO_RAM_PHASE)
            r_char <= data_in;
         if (r_phase == VIDEO_ROM_PHASE)
            r_rom <= data_in;
         if (w_load)
            r_shift <= w_active ? r_rom : '0;
         else if (r_phase[0])
            r_shift <= {r_shift[6:0], 1'b0};
      end
   end
endmodule

// File: tb/tb_pet_video_timing.sv
// tb_pet_video_timing: directed checks of slot timing, CRTC geometry, fetch addressing and pixels.
module tb_pet_video_timing;
   logic        clk16 = 1'b0;
   logic        reset_n;
   logic        pi_select, pi_strobe, video_select, video_ram_strobe, video_rom_strobe;
   logic        cpu_select, io_select, cpu_strobe, video, h_sync, h_active, v_sync, v_active;
   logic [11:0] addr_out;
   logic [7:0]  data_in;
   logic [7:0]  h_char_total = 8'd5, h_char_displayed = 8'd3, h_sync_pos = 8'd4;
   logic [3:0]  h_sync_width = 4'd1, v_sync_width = 4'd1;
   logic [4:0]  v_char_height = 5'd7, v_adjust = 5'd4;
   logic [6:0]  v_char_total = 7'd4, v_char_displayed = 7'd2, v_sync_pos = 7'd3;
   logic [12:0] outs;
   int          checks = 0, errors = 0;

   pet_video_timing dut (
      .clk16(clk16), .reset_n(reset_n), .pi_select(pi_select), .pi_strobe(pi_strobe),
      .video_select(video_select), .video_ram_strobe(video_ram_strobe),
      .video_rom_strobe(video_rom_strobe), .cpu_select(cpu_select), .io_select(io_select),
      .cpu_strobe(cpu_strobe), .addr_out(addr_out), .data_in(data_in),
      .h_char_total(h_char_total), .h_char_displayed(h_char_displayed), .h_sync_pos(h_sync_pos),
      .h_sync_width(h_sync_width), .v_char_height(v_char_height), .v_char_total(v_char_total),
      .v_char_displayed(v_char_displayed), .v_sync_pos(v_sync_pos), .v_sync_width(v_sync_width),
      .v_adjust(v_adjust), .video(video), .h_sync(h_sync), .h_active(h_active), .v_sync(v_sync),
      .v_active(v_active)
   );

   always #5 clk16 = ~clk16;

   // Screen RAM holds address+0x41; every char-ROM byte reads back as 0xA5.
   assign data_in = video_rom_strobe ? 8'hA5 : addr_out[7:0] + 8'h41;
   assign outs = {pi_select, pi_strobe, video_select, video_ram_strobe, video_rom_strobe, cpu_select,
                  io_select, cpu_strobe, video, h_sync, h_active, v_sync, v_active};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   initial begin
      int          k, c, first_ram, first_addr, nfall, first_hs, hs2, first_ha, vs0, vs1, overlap, video_bad;
      int          falls [9];
      int          cnt [13];
      int          exp_cnt [13];
      string       names [13];
      int          a_c [8], a_e [8], r_c [4], r_e [4];
      logic [11:0] ram_a [264];
      logic [11:0] rom_a [264];
      logic [31:0] vid;
      logic [15:0] exp_pix;
      logic        prev_ram, prev_hs, prev_ha, prev_vs;
      exp_cnt = '{1536, 768, 2112, 704, 384, 1056, 1848, 1584, 264, 264, 1584, 528, 1056};
      names   = '{"v_active", "v_sync", "h_active", "h_sync", "video", "cpu_strobe", "io_select",
                  "cpu_select", "rom_strobe", "ram_strobe", "video_select", "pi_strobe", "pi_select"};
      a_c = '{0, 2, 5, 44, 48, 53, 96, 239};
      a_e = '{0, 2, 5, 2, 3, 8, 6, 17};
      r_c = '{18, 19, 43, 48};
      r_e = '{32'h413, 32'h423, 32'h427, 32'h440};
      exp_pix = 16'hCC33;
      foreach (cnt[b]) cnt[b] = 0;
      first_ram = -1; first_addr = -1; nfall = 0; first_hs = -1; hs2 = -1; first_ha = -1;
      vs0 = -1; vs1 = -1; overlap = 0; video_bad = 0; vid = '0;
      prev_ram = 1'b0; prev_hs = 1'b0; prev_ha = 1'b0; prev_vs = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk16);
      chk("reset_outs", 32'(outs), 0);
      chk("reset_addr", 32'(addr_out), 0);
      reset_n = 1'b1;
      k = 0;
      repeat (8448) begin
         @(negedge clk16);
         k++;
         c = k / 16;
         if (video_ram_strobe && c < 264) ram_a[c] = addr_out;
         if (video_rom_strobe && c < 264) rom_a[c] = addr_out;
         if (video_ram_strobe && first_ram < 0) begin
            first_ram = k;
            first_addr = int'(addr_out);
         end
         if (prev_ram && !video_ram_strobe && nfall < 9) begin
            falls[nfall] = k;
            nfall++;
         end
         if (k < 32) vid[k] = video;
         if (h_sync && !prev_hs) begin
            if (first_hs < 0) first_hs = k;
            else if (hs2 < 0) hs2 = k;
         end
         if (h_active && !prev_ha && first_ha < 0) first_ha = k;
         if (v_sync && !prev_vs) begin
            if (vs0 < 0) vs0 = k;
            else if (vs1 < 0) vs1 = k;
         end
         if (k > 4224) begin
            for (int b = 0; b < 13; b++) cnt[b] += int'(outs[b]);
            if (int'(pi_select) + int'(video_select) + int'(cpu_select) > 1) overlap++;
            if (video && !(h_active && v_active)) video_bad++;
         end
         prev_ram = video_ram_strobe;
         prev_hs = h_sync;
         prev_ha = h_active;
         prev_vs = v_sync;
      end
      chk("first_ram_strobe", first_ram, 5);
      chk("first_ram_addr", first_addr, 0);
      chk("ram_fall_count", nfall, 9);
      for (int i = 0; i < 8; i++) chk($sformatf("ram_period%0d", i), falls[i+1] - falls[i], 16);
      for (int b = 0; b < 13; b++) chk({"count_", names[b]}, cnt[b], exp_cnt[b]);
      chk("slot_overlap", overlap, 0);
      chk("video_outside_active", video_bad, 0);
      chk("first_h_active", first_ha, 16);
      chk("first_h_sync", first_hs, 80);
      chk("line_period", hs2 - first_hs, 96);
      chk("first_v_sync", vs0, 2304);
      chk("frame_period", vs1 - vs0, 4224);
      for (int i = 0; i < 8; i++) chk($sformatf("ram_addr_c%0d", a_c[i]), 32'(ram_a[a_c[i]]), a_e[i]);
      for (int i = 0; i < 4; i++) chk($sformatf("rom_addr_c%0d", r_c[i]), 32'(rom_a[r_c[i]]), r_e[i]);
      chk("pixel_pre_load", 32'(vid[15]), 0);
      for (int i = 16; i < 32; i++) chk($sformatf("pixel_k%0d", i), 32'(vid[i]), 32'(exp_pix[31-i]));
      for (int i = 0; i < 200 && k % 96 != 39; i++) begin
         @(negedge clk16);
         k++;
      end
      chk("midline_reach", k % 96, 39);
      chk("pre_reset_video_select", 32'(video_select), 1);
      reset_n = 1'b0;
      #1;
      chk("midline_reset_outs", 32'(outs), 0);
      chk("midline_reset_addr", 32'(addr_out), 0);
      @(negedge clk16);
      @(negedge clk16);
      reset_n = 1'b1;
      first_ram = -1; first_addr = -1; first_ha = -1; prev_ha = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk16);
         if (video_ram_strobe && first_ram < 0) begin
            first_ram = i;
            first_addr = int'(addr_out);
         end
         if (h_active && !prev_ha && first_ha < 0) first_ha = i;
         prev_ha = h_active;
      end
      chk("restart_ram_strobe", first_ram, 5);
      chk("restart_ram_addr", first_addr, 0);
      chk("restart_h_active", first_ha, 16);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pet_video_timing.md
Name: pet_video_timing

Overview:
- Single-clock bus-slot sequencer and CRTC-style character video generator for the PET clone.
- Divides each 16-cycle character period of clk16 into Pi, video and CPU slots, and issues the select/strobe outputs for each slot.
- Uses the video slot to fetch a screen-RAM character code, then the matching character-ROM byte, and serialises that byte to pixels.
- Generates h/v sync and active signals from runtime CRTC registers.

Parameters:
- none. All timing is set through runtime register ports.

Ports:
- clk16  in  1  16 MHz system clock. All logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pi_select  out  1  Pi bus slot (phases 0-3).
- pi_strobe  out  1  Pi access strobe (phases 1-2).
- video_select  out  1  video slot (phases 4-9).
- video_ram_strobe  out  1  screen-RAM read strobe (phase 5).
- video_rom_strobe  out  1  char-ROM read strobe (phase 8).
- cpu_select  out  1  CPU slot (phases 10-15).
- io_select  out  1  IO decode window (phases 9-15).
- cpu_strobe  out  1  CPU access strobe (phases 11-14).
- addr_out  out  12  video fetch address.
- data_in  in  8  fetched RAM/ROM byte.
- h_char_total  in  8  last horizontal character index (total-1).
- h_char_displayed  in  8  number of displayed characters per line.
- h_sync_pos  in  8  character index where h_sync starts.
- h_sync_width  in  4  h_sync width, in characters.
- v_char_height  in  5  last scanline index within a character row (height-1).
- v_char_total  in  7  last character-row index.
- v_char_displayed  in  7  number of displayed character rows.
- v_sync_pos  in  7  character row where v_sync starts.
- v_sync_width  in  4  v_sync width, in character rows.
- v_adjust  in  5  extra scanlines appended after the last row.
- video  out  1  pixel output.
- h_sync, h_active, v_sync, v_active  out  1 each  timing outputs, all active-high.

Behaviour:
- Phase counter:
  - 4-bit phase counter, free-running 0..15.
  - Pixel enable on even phases gives an 8 MHz pixel clock, so one character = 8 pixels = 16 clk16 = 1 µs.
  - All selects and strobes are registered, active-high, and decoded from the phase ranges listed in Ports.
- Fetch addressing:
  - addr_out is stable from one cycle before each strobe rises until one cycle after it falls.
  - data_in is captured on the clk16 edge where the strobe falls.
  - During video_ram_strobe: addr_out = ma, where ma = row_start + h.
  - During video_rom_strobe: addr_out = {char_code[7:0], ra[3:0]}, using the captured RAM byte.
- Pixel shifter:
  - Loads the captured ROM byte at phase 15 when the current character is active; otherwise loads 0.
  - Shifts MSB-first on each pixel enable.
  - video = shifter MSB.
- Horizontal counter:
  - h counts 0..h_char_total, advancing at phase 15, then wraps to 0.
  - h_active = (h < h_char_displayed).
  - h_sync = (h_sync_pos <= h < h_sync_pos + h_sync_width).
  - h_active and h_sync are delayed one character so they align with the pixels from the shifter.
- Vertical counters:
  - ra increments at each h wrap and runs 0..v_char_height; at wrap, v increments and row_start += h_char_displayed.
  - After row v_char_total, run v_adjust extra scanlines. Then v = 0, ra = 0, row_start = 0 (start of frame).
  - v_adjust = 0 means no extra scanlines.
  - v_active = (v < v_char_displayed), excluding the adjust scanlines.
  - v_sync = (v_sync_pos <= v < v_sync_pos + v_sync_width).
- Boundary rules:
  - Register changes take effect at the next counter compare; counters never hang.
  - Any counter found beyond its total wraps on its next advance.
  - Zero sync width produces no sync pulse.
- Reset (asynchronous, reset_n low):
  - phase, h, v, ra, row_start, shifter all 0.
  - Every select, strobe and sync output low; addr_out = 0; video = 0.
  - First character starts at phase 0 after release.

Decomposition:
- Shared package: phase constants (PI_START, VIDEO_RAM_PHASE = 5, VIDEO_ROM_PHASE = 8, CPU_START = 10, LOAD_PHASE = 15) and the register field widths.
- One sub-module, crtc_timing: the h/v/ra/row_start counters and the sync/active compare logic.
- The top level holds the phase decoder, address mux and pixel shifter.

Test Plan:
- Slot timing: free run after reset -> video_ram_strobe falls exactly 16 clk16 apart; no two of pi_select, video_select, cpu_select overlap.
- Default geometry:
  - Config: h displayed 3, front porch 1, sync 1, back porch 1 (total 5); v displayed 2, fp 1, sync 1, bp 1 (total 4); height 7; adjust 4.
  - Required: line = 96 clk16 with h_active 48 clk16 and h_sync 16 clk16; frame = 44 lines; v_sync = 8 lines.
- RAM addresses: in that frame, the RAM addresses at the falling edges are 0,1,2 repeated 8 lines, then 3,4,5. Values continue past the display window without wrapping.
- ROM address: RAM byte 0x41 on scanline 3 -> ROM address 0x413.
- Pixel serialisation: ROM byte 0xA5 -> video = 1,0,1,0,0,1,0,1, each for 2 clk16, aligned with h_active.
- Reset mid-line: assert reset_n low at phase 7, h = 2 -> all outputs 0 within the same cycle; after release, phase 0 and h = 0.
